// File: rtl/alu_cmd_issuer.sv
// alu_cmd_issuer: credit-gated command front end for the 2-stage ALU with in-order tagged responses
module alu_cmd_issuer #(
    parameter int DATA_W    = 16,
    parameter int TAG_W     = 4,
    parameter int RSP_DEPTH = 4,
    parameter int ALU_LAT   = 2
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         cmd_valid,
    output logic                         cmd_ready,
    input  logic [DATA_W-1:0]            cmd_a,
    input  logic [DATA_W-1:0]            cmd_b,
    input  logic [2:0]                   cmd_op,
    input  logic [TAG_W-1:0]             cmd_tag,
    output logic [DATA_W-1:0]            alu_operand_a,
    output logic [DATA_W-1:0]            alu_operand_b,
    output logic [2:0]                   alu_op,
    output logic                         alu_valid_in,
    input  logic [DATA_W-1:0]            alu_result,
    input  logic                         alu_valid_out,
    input  logic                         alu_overflow,
    output logic                         rsp_valid,
    input  logic                         rsp_ready,
    output logic [DATA_W-1:0]            rsp_result,
    output logic                         rsp_overflow,
    output logic [TAG_W-1:0]             rsp_tag,
    output logic [$clog2(RSP_DEPTH):0]   inflight,
    output logic                         idle,
    output logic                         err_unexpected
);
    localparam int AW = $clog2(RSP_DEPTH);
    localparam int CW = AW + 1;
    localparam int RW = DATA_W + 1 + TAG_W;

    if (ALU_LAT < 1 || RSP_DEPTH < 2 || (RSP_DEPTH & (RSP_DEPTH - 1)) != 0) begin : g_param_chk
        $error("alu_cmd_issuer: RSP_DEPTH must be a power of 2 >= 2 and ALU_LAT >= 1");
    end

    logic [TAG_W-1:0] tag_q [RSP_DEPTH];
    logic [RW-1:0]    rsp_q [RSP_DEPTH];
    logic [AW-1:0]    tag_wp, tag_rp, rsp_wp, rsp_rp;
    logic [CW-1:0]    rsp_count;
    logic [CW:0]      used;
    logic             acc, ret_ok, pop;

    // every accepted command holds a credit until its response leaves the FIFO
    assign used      = {1'b0, rsp_count} + {1'b0, inflight};
    assign cmd_ready = used < (CW + 1)'(RSP_DEPTH);
    assign acc       = cmd_valid && cmd_ready;
    assign ret_ok    = alu_valid_out && inflight != '0;
    assign rsp_valid = rsp_count != '0;
    assign pop       = rsp_valid && rsp_ready;
    assign idle      = inflight == '0 && rsp_count == '0;
    assign {rsp_result, rsp_overflow, rsp_tag} = rsp_q[rsp_rp];

    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            alu_operand_a  <= '0;
            alu_operand_b  <= '0;
            alu_op         <= '0;
            alu_valid_in   <= 1'b0;
            tag_wp         <= '0;
            tag_rp         <= '0;
            rsp_wp         <= '0;
            rsp_rp         <= '0;
            rsp_count      <= '0;
            inflight       <= '0;
            err_unexpected <= 1'b0;
            for (int i = 0; i < RSP_DEPTH; i++) begin
                tag_q[i] <= '0;
                rsp_q[i] <= '0;
            end
        end else begin
            alu_valid_in <= acc;
            if (acc) begin
                alu_operand_a <= cmd_a;
                alu_operand_b <= cmd_b;
                alu_op        <= cmd_op;
                tag_q[tag_wp] <= cmd_tag;
                tag_wp        <= tag_wp + 1'b1;
            end
            if (ret_ok) begin
                rsp_q[rsp_wp] <= {alu_result, alu_overflow, tag_q[tag_rp]};
                rsp_wp        <= rsp_wp + 1'b1;
                tag_rp        <= tag_rp + 1'b1;
            end
            if (pop)
                rsp_rp <= rsp_rp + 1'b1;
            if (alu_valid_out && inflight == '0)
                err_unexpected <= 1'b1;
            inflight  <= inflight + CW'(acc) - CW'(ret_ok);
            rsp_count <= rsp_count + CW'(ret_ok) - CW'(pop);
        end

    always_ff @(posedge clk)
        if (rst_n)
            assert (!(ret_ok && rsp_count == CW'(RSP_DEPTH) && !pop));
endmodule

// File: tb/tb_alu_cmd_issuer.sv
// tb_alu_cmd_issuer: directed and random stimulus against a transaction-level model of the issuer
module tb_alu_cmd_issuer;
    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        cmd_valid, cmd_ready;
    logic [15:0] cmd_a, cmd_b;
    logic [2:0]  cmd_op;
    logic [3:0]  cmd_tag;
    logic [15:0] alu_operand_a, alu_operand_b, alu_result;
    logic [2:0]  alu_op;
    logic        alu_valid_in, alu_valid_out, alu_overflow;
    logic        rsp_valid, rsp_ready, rsp_overflow;
    logic [15:0] rsp_result;
    logic [3:0]  rsp_tag;
    logic [2:0]  inflight;
    logic        idle, err_unexpected;
    logic        spur;

    always #5 clk = ~clk;

    alu_cmd_issuer #(.DATA_W(16), .TAG_W(4), .RSP_DEPTH(DEPTH), .ALU_LAT(2)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_a(cmd_a), .cmd_b(cmd_b),
        .cmd_op(cmd_op), .cmd_tag(cmd_tag),
        .alu_operand_a(alu_operand_a), .alu_operand_b(alu_operand_b), .alu_op(alu_op),
        .alu_valid_in(alu_valid_in), .alu_result(alu_result), .alu_valid_out(alu_valid_out),
        .alu_overflow(alu_overflow),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_result(rsp_result),
        .rsp_overflow(rsp_overflow), .rsp_tag(rsp_tag),
        .inflight(inflight), .idle(idle), .err_unexpected(err_unexpected)
    );

    function automatic logic [16:0] alu_fn(input logic [15:0] a, input logic [15:0] b, input logic [2:0] op);
        logic [15:0] s;
        case (op)
            3'd0: begin s = a + b; return {a[15] == b[15] && s[15] != a[15], s}; end
            3'd1: begin s = a - b; return {a[15] != b[15] && s[15] != a[15], s}; end
            3'd2: return {1'b0, a & b};
            3'd3: return {1'b0, a | b};
            3'd4: return {1'b0, a ^ b};
            3'd5: return {1'b0, a << 1};
            3'd6: return {1'b0, a >> 1};
            default: return 17'd0;
        endcase
    endfunction

    // two-stage ALU stand-in sharing the issuer's reset
    logic        v1, v2, o1, o2;
    logic [15:0] r1, r2;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            {v1, v2, o1, o2} <= '0;
            r1 <= '0;
            r2 <= '0;
        end else begin
            v1 <= alu_valid_in;
            {o1, r1} <= alu_fn(alu_operand_a, alu_operand_b, alu_op);
            v2 <= v1;
            o2 <= o1;
            r2 <= r1;
        end
    assign alu_valid_out = v2 | spur;
    assign alu_result    = r2;
    assign alu_overflow  = o2;

    typedef struct {
        int          acc;
        logic [15:0] res;
        logic        ovf;
        logic [3:0]  tag;
    } exp_t;

    exp_t        q[$];
    int          n = 0;
    int          n_cmp = 0;
    int          n_bad = 0;
    bit          last_acc = 0;
    bit          err_exp = 0;
    logic [15:0] la, lb;
    logic [2:0]  lop;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    // one cycle: check visible state at the negedge, drive inputs, advance the model
    task automatic step(input bit cv, input logic [15:0] a, input logic [15:0] b, input logic [2:0] op,
                        input logic [3:0] tag, input bit rr, input bit sp);
        int          inf;
        bit          rv, acc;
        logic [16:0] r;
        exp_t        e;
        inf = 0;
        foreach (q[i]) if (n < q[i].acc + 3) inf++;
        rv = q.size() != 0 && n >= q[0].acc + 3;
        check("cmd_ready", cmd_ready, q.size() < DEPTH);
        check("inflight", inflight, inf);
        check("rsp_valid", rsp_valid, rv);
        check("idle", idle, q.size() == 0);
        check("err_unexpected", err_unexpected, err_exp);
        check("alu_valid_in", alu_valid_in, last_acc);
        if (rv) begin
            check("rsp_result", rsp_result, q[0].res);
            check("rsp_overflow", rsp_overflow, q[0].ovf);
            check("rsp_tag", rsp_tag, q[0].tag);
        end
        if (last_acc) begin
            check("alu_operand_a", alu_operand_a, la);
            check("alu_operand_b", alu_operand_b, lb);
            check("alu_op", alu_op, lop);
        end
        cmd_valid = cv; cmd_a = a; cmd_b = b; cmd_op = op; cmd_tag = tag;
        rsp_ready = rr; spur = sp;
        acc = cv && q.size() < DEPTH;
        if (rv && rr) void'(q.pop_front());
        if (acc) begin
            r = alu_fn(a, b, op);
            e.acc = n + 1; e.res = r[15:0]; e.ovf = r[16]; e.tag = tag;
            q.push_back(e);
        end
        if (sp) err_exp = 1;
        last_acc = acc; la = a; lb = b; lop = op;
        @(posedge clk);
        @(negedge clk);
        n++;
    endtask

    task automatic idle_steps(input int k, input bit rr);
        for (int i = 0; i < k; i++) step(0, 16'h0, 16'h0, 3'd0, 4'd0, rr, 0);
    endtask

    initial begin
        rst_n = 0; cmd_valid = 0; cmd_a = 0; cmd_b = 0; cmd_op = 0; cmd_tag = 0;
        rsp_ready = 0; spur = 0;
        #3;
        check("rst_alu_valid_in", alu_valid_in, 0);
        check("rst_alu_operand_a", alu_operand_a, 0);
        check("rst_inflight", inflight, 0);
        check("rst_rsp_valid", rsp_valid, 0);
        check("rst_idle", idle, 1);
        check("rst_cmd_ready", cmd_ready, 1);
        check("rst_err", err_unexpected, 0);
        @(negedge clk);
        rst_n = 1;

        // single ADD
        step(1, 16'h0003, 16'h0004, 3'd0, 4'd5, 0, 0);
        idle_steps(3, 0);
        check("add_result", rsp_result, 16'h0007);
        check("add_tag", rsp_tag, 4'd5);
        idle_steps(2, 1);

        // four back-to-back commands held in the FIFO
        step(1, 16'd10, 16'd1, 3'd1, 4'd1, 0, 0);
        step(1, 16'hF0F0, 16'h0FF0, 3'd2, 4'd2, 0, 0);
        step(1, 16'h1200, 16'h0034, 3'd3, 4'd3, 0, 0);
        step(1, 16'hFF00, 16'h0F0F, 3'd4, 4'd4, 0, 0);
        for (int i = 0; i < 4; i++) step(1, 16'h1111, 16'h2222, 3'd0, 4'd9, 0, 0);
        check("strm_full_ready", cmd_ready, 0);
        check("strm_res0", rsp_result, 16'h0009);
        check("strm_tag0", rsp_tag, 4'd1);
        step(0, 16'h0, 16'h0, 3'd0, 4'd0, 1, 0);
        check("strm_res1", rsp_result, 16'h00F0);
        check("strm_tag1", rsp_tag, 4'd2);
        idle_steps(4, 1);

        // full FIFO: a pop frees a credit only for the following cycle
        for (int i = 0; i < 4; i++) step(1, 16'(i), 16'd7, 3'd0, 4'(i), 0, 0);
        idle_steps(4, 0);
        check("full_ready", cmd_ready, 0);
        step(1, 16'h00AA, 16'h0001, 3'd0, 4'hA, 1, 0);
        check("freed_ready", cmd_ready, 1);
        step(1, 16'h00AA, 16'h0001, 3'd0, 4'hA, 0, 0);
        idle_steps(8, 1);

        // opcode passthrough
        step(1, 16'h8001, 16'h0000, 3'd5, 4'd6, 0, 0);
        step(1, 16'h8001, 16'h1234, 3'd7, 4'd7, 0, 0);
        idle_steps(2, 0);
        check("op5_result", rsp_result, 16'h0002);
        step(0, 16'h0, 16'h0, 3'd0, 4'd0, 1, 0);
        check("op7_result", rsp_result, 16'h0000);
        idle_steps(2, 1);

        // spurious ALU return while idle
        step(0, 16'h0, 16'h0, 3'd0, 4'd0, 1, 1);
        idle_steps(3, 1);
        check("err_sticky", err_unexpected, 1);

        // reset with three commands in flight
        for (int i = 0; i < 3; i++) step(1, 16'h0100, 16'(i), 3'd0, 4'(i), 0, 0);
        rst_n = 0; cmd_valid = 0;
        #1;
        check("mid_rst_inflight", inflight, 0);
        check("mid_rst_rsp_valid", rsp_valid, 0);
        check("mid_rst_idle", idle, 1);
        check("mid_rst_cmd_ready", cmd_ready, 1);
        check("mid_rst_alu_valid_in", alu_valid_in, 0);
        check("mid_rst_err", err_unexpected, 0);
        q.delete();
        last_acc = 0;
        err_exp = 0;
        @(negedge clk);
        rst_n = 1;

        // random traffic including signed-overflow cases
        for (int i = 0; i < 2000; i++)
            step($urandom_range(0, 9) < 7, 16'($urandom), 16'($urandom), 3'($urandom),
                 4'($urandom), $urandom_range(0, 1) == 1, 0);
        idle_steps(10, 1);
        check("end_idle", idle, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
